uart_reg_bank_gen: RTL and testbench

- Parametrised successor of the team's UART-controlled register bank.
- Holds N_REGS configuration registers of REG_W bits each, plus one read-only status register.
- Registers are written and read back over a byte-oriented UART command protocol.
- Sits between the board UART pins and the GPS signal generator core. Drives flattened configuration outputs and latches completion events from the core.

---
 rtl/uart_reg_pkg.sv | 13 +
 rtl/reg_cmd_parser.sv | 168 ++++++++++++++++
 rtl/uart_rx.sv | 86 ++++++++
 rtl/uart_tx.sv | 62 ++++++
 rtl/uart_reg_bank_gen.sv | 79 +++++++
 tb/tb_uart_reg_bank_gen.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/uart_reg_pkg.sv
// Shared constants for the UART register bank: response codes,
// command layout and parser state encoding.
package uart_reg_pkg;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'h55;
  localparam int WR_BIT = 7;
  localparam int N_STAT = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GET  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;
endpackage

// File: rtl/reg_cmd_parser.sv
// Command FSM, staging register, timeout and response sequencer.
// CHECKSUM_EN adds a trailing XOR byte to commands and read replies.
module reg_cmd_parser
  import uart_reg_pkg::*;
#(
  parameter int N_REGS       = 8,
  parameter int REG_W        = 16,
  parameter int TIMEOUT_CLKS = 200000,
  parameter int NB           = (REG_W + 7) / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic            tx_busy,
  input  logic [NB*8-1:0] rd_data,
  output logic [6:0]      addr_out,
  output logic            wr_en,
  output logic [REG_W-1:0] wr_data,
  output logic            stat_clr,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic            busy
);
`ifdef CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int DW = NB * 8;
  localparam int TB = (NB + CK) * 8;
  localparam logic [6:0]  NR    = 7'(N_REGS);
  localparam logic [2:0]  NDAT  = 3'(NB);
  localparam logic [2:0]  NWR   = 3'(NB + CK);
  localparam logic [2:0]  NRD   = 3'(CK);
  localparam logic [31:0] TMO_L = 32'(TIMEOUT_CLKS - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    chk_q, chk_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] stage_q, stage_d;
  logic [31:0]   tmo_q, tmo_d;
  logic [TB-1:0] txbuf_q, txbuf_d;
  logic [2:0]    txn_q, txn_d;
  logic          infl_q, infl_d;

  logic       is_wr, reg_ok, stat_ok, chk_ok;
  logic [2:0] need;

`ifdef CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [DW-1:0] d);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < NB; i++) x ^= d[i*8 +: 8];
    return x;
  endfunction
`endif

  assign is_wr    = cmd_q[WR_BIT];
  assign addr_out = cmd_q[6:0];
  assign reg_ok   = addr_out < NR;
  assign stat_ok  = (addr_out == NR) && !is_wr;
  // XOR over every byte including the checksum is zero when intact
  assign chk_ok   = (CK == 0) || (chk_q == 8'h00);
  assign need     = is_wr ? NWR : NRD;
  assign wr_data  = stage_q[REG_W-1:0];
  assign tx_data  = txbuf_q[TB-1 -: 8];
  assign busy     = state_q != S_IDLE;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    chk_d    = chk_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    tmo_d    = tmo_q;
    txbuf_d  = txbuf_q;
    txn_d    = txn_q;
    infl_d   = infl_q;
    wr_en    = 1'b0;
    stat_clr = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          cnt_d   = '0;
          tmo_d   = '0;
          stage_d = '0;
          state_d = (rx_data[WR_BIT] || CK != 0) ? S_GET : S_EXEC;
        end
      end
      S_GET: begin
        tmo_d = tmo_q + 32'd1;
        if (rx_valid) begin
          tmo_d = '0;
          chk_d = chk_q ^ rx_data;
          cnt_d = cnt_q + 3'd1;
          if (is_wr && cnt_q < NDAT)
            stage_d = (stage_q << 8) | DW'(rx_data);
          if (cnt_q + 3'd1 == need) state_d = S_EXEC;
        end else if (tmo_q >= TMO_L) begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        infl_d  = 1'b0;
        state_d = S_SEND;
        txn_d   = 3'd1;
        txbuf_d = TB'(NAK) << (TB - 8);
        if (chk_ok && is_wr && reg_ok) begin
          wr_en   = 1'b1;
          txbuf_d = TB'(ACK) << (TB - 8);
        end else if (chk_ok && !is_wr && (reg_ok || stat_ok)) begin
          stat_clr = stat_ok;
          txn_d    = NWR;
`ifdef CHECKSUM_EN
          txbuf_d  = {rd_data, xor_bytes(rd_data)};
`else
          txbuf_d  = rd_data;
`endif
        end
      end
      S_SEND: begin
        // wait for tx to report busy before trusting its idle flag again
        if (infl_q) begin
          if (tx_busy) infl_d = 1'b0;
        end else if (!tx_busy) begin
          if (txn_q != 3'd0) begin
            tx_start = 1'b1;
            txn_d    = txn_q - 3'd1;
            txbuf_d  = txbuf_q << 8;
            infl_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      tmo_q   <= '0;
      txbuf_q <= '0;
      txn_q   <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      txbuf_q <= txbuf_d;
      txn_q   <= txn_d;
      infl_q  <= infl_d;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; valid_out pulses one cycle per received byte.
// Input is double-flopped and each bit is sampled at mid-bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out
);
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  sync_q, sync_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        rx_s;

  assign rx_s      = sync_q[1];
  assign data_out  = byte_q;
  assign valid_out = valid_q;

  always_comb begin
    sync_d  = {sync_q[0], rx_in};
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          byte_d = {rx_s, byte_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = rx_s;
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; start_in is accepted only while busy_out is low.
// tx_out is registered so the line never glitches.
module uart_tx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       start_in,
  output logic       tx_out,
  output logic       busy_out
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

  logic        busy_q, busy_d;
  logic [9:0]  sh_q, sh_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        tx_q, tx_d;

  assign tx_out   = tx_q;
  assign busy_out = busy_q;

  always_comb begin
    busy_d = busy_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    if (!busy_q) begin
      if (start_in) begin
        busy_d = 1'b1;
        sh_d   = {1'b1, data_in, 1'b0};
        cnt_d  = '0;
        bit_d  = '0;
      end
    end else if (cnt_q == FULL) begin
      cnt_d = '0;
      sh_d  = {1'b1, sh_q[9:1]};
      if (bit_q == 4'd9) busy_d = 1'b0;
      else bit_d = bit_q + 4'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    tx_d = busy_d ? sh_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sh_q   <= '1;
      cnt_q  <= '0;
      bit_q  <= '0;
      tx_q   <= 1'b1;
    end else begin
      busy_q <= busy_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
    end
  end
endmodule

// File: rtl/uart_reg_bank_gen.sv
// UART-controlled bank of N_REGS x REG_W registers plus sticky status.
// Define CHECKSUM_EN for XOR-checksummed commands and replies.
module uart_reg_bank_gen
  import uart_reg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 142,
  parameter int N_REGS       = 8,
  parameter int REG_W        = 16,
  parameter int TIMEOUT_CLKS = 200000
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic                    rx_in,
  output logic                    tx_out,
  input  logic [N_STAT-1:0]       status_in,
  output logic [N_REGS*REG_W-1:0] regs_out,
  output logic                    busy_out
);
  localparam int NB = (REG_W + 7) / 8;
  localparam int DW = NB * 8;
  localparam logic [6:0] NR = 7'(N_REGS);

  logic [N_REGS*REG_W-1:0] regs_q, regs_d;
  logic [N_STAT-1:0]       flags_q, flags_d;
  logic [7:0]       rx_data, tx_data;
  logic             rx_valid, tx_start, tx_busy;
  logic             wr_en, stat_clr;
  logic [6:0]       addr;
  logic [REG_W-1:0] wr_data;
  logic [DW-1:0]    rd_data;

  assign regs_out = regs_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk_in), .rst_n(rst_in_n), .rx_in(rx_in),
    .data_out(rx_data), .valid_out(rx_valid)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk_in), .rst_n(rst_in_n), .data_in(tx_data),
    .start_in(tx_start), .tx_out(tx_out), .busy_out(tx_busy)
  );

  reg_cmd_parser #(
    .N_REGS(N_REGS), .REG_W(REG_W), .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_parser (
    .clk(clk_in), .rst_n(rst_in_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .rd_data(rd_data), .addr_out(addr), .wr_en(wr_en),
    .wr_data(wr_data), .stat_clr(stat_clr),
    .tx_data(tx_data), .tx_start(tx_start), .busy(busy_out)
  );

  always_comb begin
    rd_data = '0;
    if (addr == NR) rd_data = DW'(flags_q);
    for (int k = 0; k < N_REGS; k++)
      if (addr == 7'(k)) rd_data = DW'(regs_q[k*REG_W +: REG_W]);
  end

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < N_REGS; k++)
      if (wr_en && addr == 7'(k)) regs_d[k*REG_W +: REG_W] = wr_data;
  end

  // clear drops exactly the snapshot; same-cycle events still set
  assign flags_d = stat_clr ? status_in : (flags_q | status_in);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      regs_q  <= '0;
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_uart_reg_bank_gen.sv
// Scoreboard bench for uart_reg_bank_gen: directed commands over rx,
// a UART monitor on tx pops expected bytes from a queue.
module tb_uart_reg_bank_gen;
  localparam int CPB = 8;
  localparam int NR  = 8;
  localparam int RW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;
  logic [7:0] status_in = 8'h00;
  logic tx_out, busy_out;
  logic [NR*RW-1:0] regs_out;

  always #5 clk = ~clk;

  uart_reg_bank_gen #(
    .CLKS_PER_BIT(CPB), .N_REGS(NR), .REG_W(RW), .TIMEOUT_CLKS(400)
  ) dut (
    .clk_in(clk), .rst_in_n(rst_n), .rx_in(rx_in), .tx_out(tx_out),
    .status_in(status_in), .regs_out(regs_out), .busy_out(busy_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rst_epoch = 0;
  logic [7:0] exp_q[$];
  logic [RW-1:0] mreg[NR];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*RW-1:0] model_vec();
    logic [NR*RW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*RW +: RW] = mreg[k];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // ck: 0 = correct checksum, 1 = checksum 0x00, 2 = no checksum byte
  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input int ck);
    logic [7:0] x;
    x = b0;
    send_byte(b0);
    if (n > 1) begin send_byte(b1); x ^= b1; end
    if (n > 2) begin send_byte(b2); x ^= b2; end
`ifdef CHECKSUM_EN
    if (ck == 0) send_byte(x);
    else if (ck == 1) send_byte(8'h00);
`else
    if (ck > 2) $display("note: checksum mode %0d ignored (%0h)", ck, x);
`endif
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic exp_read(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
`ifdef CHECKSUM_EN
    exp_q.push_back(v[15:8] ^ v[7:0]);
`endif
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_out) break;
    end
    check(name, {127'b0, busy_out}, 128'd0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] b;
    int ep;
    forever begin
      @(negedge clk);
      if (rst_n && tx_out === 1'b0) begin
        ep = rst_epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (CPB) @(negedge clk);
        if (ep == rst_epoch) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_unexpected: got %02h expected none", b);
          end else begin
            check("tx_byte", {120'b0, b}, {120'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int k = 0; k < NR; k++) mreg[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {127'b0, tx_out}, 128'd1);
    check("rst_busy", {127'b0, busy_out}, 128'd0);
    check("rst_regs", {'0, regs_out}, 128'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    exp_q.push_back(8'hAA);
    send_cmd(8'h83, 8'h12, 8'h34, 3, 0);
    wait_idle("wr_busy");
    mreg[3] = 16'h1234;
    check("wr_regs", {'0, regs_out}, {'0, model_vec()});

    exp_read(16'h1234);
    send_cmd(8'h03, 8'h00, 8'h00, 1, 0);
    wait_idle("rd_busy");
    check("rd_regs", {'0, regs_out}, {'0, model_vec()});

    exp_q.push_back(8'h55);
    send_cmd(8'h8A, 8'h00, 8'h01, 3, 0);
    wait_idle("inv_busy");
    check("inv_regs", {'0, regs_out}, {'0, model_vec()});

    exp_q.push_back(8'h55);
    send_cmd(8'h88, 8'h00, 8'h00, 3, 0);
    wait_idle("wstat_busy");
    check("wstat_regs", {'0, regs_out}, {'0, model_vec()});

    @(negedge clk) status_in = 8'h05;
    @(negedge clk) status_in = 8'h00;
    exp_read(16'h0005);
    send_cmd(8'h08, 8'h00, 8'h00, 1, 0);
    wait_idle("stat1_busy");
    exp_read(16'h0000);
    send_cmd(8'h08, 8'h00, 8'h00, 1, 0);
    wait_idle("stat2_busy");

`ifndef CHECKSUM_EN
    exp_read(16'h0000);
    fork
      send_cmd(8'h08, 8'h00, 8'h00, 1, 0);
      begin
        int j;
        for (j = 0; j < 3000; j++) begin
          @(posedge clk);
          #1;
          if (busy_out) break;
        end
        status_in = 8'h01;
        @(posedge clk);
        #1 status_in = 8'h00;
      end
    join
    wait_idle("stat3_busy");
    exp_read(16'h0001);
    send_cmd(8'h08, 8'h00, 8'h00, 1, 0);
    wait_idle("stat4_busy");
`endif

    send_cmd(8'h81, 8'hAB, 8'h00, 2, 2);
    repeat (500) @(negedge clk);
    check("tmo_busy", {127'b0, busy_out}, 128'd0);
    check("tmo_regs", {'0, regs_out}, {'0, model_vec()});
    exp_q.push_back(8'hAA);
    send_cmd(8'h81, 8'h00, 8'h07, 3, 0);
    wait_idle("tmo_wr_busy");
    mreg[1] = 16'h0007;
    check("tmo_wr_regs", {'0, regs_out}, {'0, model_vec()});

`ifdef CHECKSUM_EN
    exp_q.push_back(8'h55);
    send_cmd(8'h83, 8'h56, 8'h78, 3, 1);
    wait_idle("badck_busy");
    check("badck_regs", {'0, regs_out}, {'0, model_vec()});
`endif

    send_cmd(8'h03, 8'h00, 8'h00, 1, 0);
    for (int i = 0; i < 2000; i++) begin
      if (tx_out === 1'b0) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    rst_epoch++;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {127'b0, tx_out}, 128'd1);
    check("rst_mid_regs", {'0, regs_out}, 128'd0);
    for (int k = 0; k < NR; k++) mreg[k] = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    exp_read(16'h0000);
    send_cmd(8'h03, 8'h00, 8'h00, 1, 0);
    wait_idle("post_rst_busy");
    check("post_rst_regs", {'0, regs_out}, {'0, model_vec()});

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
